conv_window_linebuf: RTL and testbench
======================================

# conv_window_linebuf

Streaming sliding-window generator for the conv stage that follows the 2×2 average pool, for example the 6×14×14 pooled maps feeding the 5×5 conv. It accepts one pooled pixel per handshake in raster order, one channel plane after another. It buffers K−1 rows in line buffers and emits every valid K×K window as a registered, backpressure-aware stream. This replaces whole-array matrix ports with a pixel stream, so the conv MAC array sees one window per cycle.

## Interface
- `width`, 14: input plane columns
- `height`, 14: input plane rows
- `depth`, 6: channel planes per frame
- `k`, 5: window size. Constraint: 2 ≤ k ≤ min(width, height).
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset)
- `in_pix` in 16: pooled pixel, unsigned 16-bit
- `in_valid` in 1: `in_pix` is valid
- `in_ready` out 1: block accepts `in_pix` this cycle
- `out_win[0:k-1][0:k-1]` out 16 each: window. `[r][c]`: r=0 is the top (oldest) row, c=0 is the leftmost column.
- `out_valid` out 1: `out_win` is valid
- `out_ready` in 1: downstream accepts the window
- `out_ch` out ceil(log2(depth)): channel index of the window
- `out_last` out 1: last window of the current channel plane
- `frame_done` out 1: one-cycle pulse when the last window of channel depth−1 is accepted

## Operation
- Accept condition: `in_valid && in_ready`. Only accepted pixels change any state.
- Counters `col` (0..width−1), `row` (0..height−1) and `ch` (0..depth−1) give the position of the next pixel to accept.
- On accept:
  - The window shift registers shift left; the new column is loaded from the line-buffer taps plus `in_pix`.
  - The line buffers shift by one.
  - `col` increments; at width−1 it wraps to 0 and `row` increments.
  - At the last row and last column, `row` wraps to 0 and `ch` increments. At depth−1, `ch` wraps to 0.
- Emit condition: the accepted pixel has `row ≥ k−1` and `col ≥ k−1`. On emit, the output register loads the window, `ch` and `last`.
  - `last` = (row == height−1 && col == width−1).
  - Each plane yields (height−k+1)·(width−k+1) windows; 100 with the defaults.
- Windows never straddle rows: emission requires `col ≥ k−1`, so all k columns come from the current rows. No flush of the shift registers is needed between rows.
- Line-buffer contents carry across plane boundaries, but are never emitted before they are overwritten, because of the `row ≥ k−1` gate.
- Control FSM:
  - FILL: `row < k−1`.
  - STREAM: emitting rows.
  - Transitions: FILL→STREAM when `row` reaches k−1 on a column wrap. STREAM→FILL on a plane wrap.
- Output register: holds `out_win`, `out_ch` and `out_last` stable while `out_valid && !out_ready`.
- `frame_done` = `out_valid && out_ready && out_last && out_ch == depth−1`.
- Arithmetic: none on pixel data. Pixels pass through bit-exact.

## Timing
- `in_ready = !out_valid || out_ready` (combinational).
- Latency: a pixel accepted at cycle t that completes a window gives `out_valid` = 1 at t+1.
- Throughput: one pixel per cycle, and one window per cycle in STREAM.
- `out_valid` update each cycle:
  - Set on an emit-accept.
  - Held while stalled.
  - Cleared when `out_ready` = 1 and there is no emit-accept.
  - Accept and output handshake in the same cycle: the new window replaces the old one, with no bubble.
- Reset values:
  - `out_valid` = 0, `out_last` = 0, `frame_done` = 0, `out_ch` = 0, `out_win` = all 0.
  - `col`/`row`/`ch` = 0, FSM = FILL.
  - `in_ready` = 1 after reset.
  - Line buffers need no reset.
- Reset mid-plane: all counters return to 0 and any pending window is dropped. The next pixel is treated as (ch 0, row 0, col 0).
- `in_valid` low: state is frozen, gaps of any length are allowed, and output is unaffected.

## Structure
- Shared `cnn_pkg`: `typedef logic [15:0] pix_t` and the default geometry constants (14, 14, 6, 5).
  - The avgpool and conv blocks use the same package.
- Sub-module `line_buffer_row`: a width-deep pix_t shift line with enable and a tap output.
  - k−1 instances, chained.
- The top holds the counters, the FSM, the k×k window registers and the output register.

## Test plan
- Ramp plane, pixel = row·14+col, `out_ready` = 1:
  - Exactly 100 windows.
  - First window: `out_win[0][0]` = 0, `[4][4]` = 60, one cycle after pixel (4,4) is accepted.
  - Last window: `[4][4]` = 195 with `out_last` = 1.
- Row boundary:
  - Window for pixel (5,4): `[0][0]` = 14, `[4][4]` = 74.
  - No window is emitted for pixels with col < 4.
- Backpressure: `out_ready` random at 30% during streaming.
  - Outputs are stable while stalled.
  - `in_ready` is low only while stalled.
  - Same 100-window sequence as the unstalled run.
- Six planes back-to-back, plane c = ramp + 1000·c:
  - `out_ch` steps 0..5 and wraps to 0.
  - `frame_done` pulses once, on the 600th window.
- Reset pulse (`rst` = 0) after 80 accepted pixels:
  - Outputs go to their reset values immediately.
  - The replayed plane matches test 1 exactly.
- Random `in_valid` gaps: window sequence identical to test 1.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and default geometry for the pooled-map / conv pipeline.
package cnn_pkg;
    typedef logic [15:0] pix_t;

    localparam int pool_width  = 14;
    localparam int pool_height = 14;
    localparam int pool_depth  = 6;
    localparam int conv_k      = 5;

    typedef enum logic {
        st_fill,
        st_stream
    } win_state_t;
endpackage

// File: rtl/line_buffer_row.sv
// One row of pixel history: a width-deep shift line; tap is the pixel
// accepted exactly width enables ago (same column, previous row).
module line_buffer_row
    import cnn_pkg::*;
#(
    parameter int width = pool_width
) (
    input  logic clk,
    input  logic en,
    input  pix_t din,
    output pix_t tap
);
    pix_t line [0:width-1];

    always_ff @(posedge clk) begin
        if (en) begin
            line[0] <= din;
            for (int i = 1; i < width; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign tap = line[width-1];
endmodule

// File: rtl/conv_window_linebuf.sv
// Streaming k x k window generator: k-1 chained line buffers feed a window
// shift register; emitted windows sit in a backpressure-aware output register.
//
// state     | meaning
// st_fill   | row < k-1, priming line buffers, no windows emitted
// st_stream | row >= k-1, one window per accepted pixel with col >= k-1
module conv_window_linebuf
    import cnn_pkg::*;
#(
    parameter int width  = pool_width,
    parameter int height = pool_height,
    parameter int depth  = pool_depth,
    parameter int k      = conv_k
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  pix_t                                     in_pix,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    output pix_t                                     out_win [0:k-1][0:k-1],
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [$clog2(depth > 1 ? depth : 2)-1:0] out_ch,
    output logic                                     out_last,
    output logic                                     frame_done
);
    localparam int colw = $clog2(width);
    localparam int roww = $clog2(height);
    localparam int chw  = $clog2(depth > 1 ? depth : 2);

    localparam logic [colw-1:0] col_last  = colw'(width - 1);
    localparam logic [colw-1:0] col_first = colw'(k - 1);
    localparam logic [roww-1:0] row_last  = roww'(height - 1);
    localparam logic [roww-1:0] row_prime = roww'(k - 2);
    localparam logic [chw-1:0]  ch_last   = chw'(depth - 1);

    logic [colw-1:0] col;
    logic [roww-1:0] row;
    logic [chw-1:0]  ch;
    win_state_t      state;

    logic accept, emit, at_col_end, at_row_end;

    pix_t lb_din  [0:k-2];
    pix_t lb_tap  [0:k-2];
    pix_t newcol  [0:k-1];
    pix_t win     [0:k-1][0:k-1];
    pix_t win_nxt [0:k-1][0:k-1];

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign at_col_end = (col == col_last);
    assign at_row_end = (row == row_last);
    assign emit       = accept && (state == st_stream) && (col >= col_first);
    assign frame_done = out_valid && out_ready && out_last && (out_ch == ch_last);

    assign lb_din[0] = in_pix;
    for (genvar i = 0; i < k - 1; i++) begin : g_lb
        if (i > 0) begin : g_chain
            assign lb_din[i] = lb_tap[i-1];
        end
        line_buffer_row #(.width(width)) u_row (
            .clk (clk),
            .en  (accept),
            .din (lb_din[i]),
            .tap (lb_tap[i])
        );
    end

    // Deepest tap is the oldest row, so it lands at the top of the new column.
    always_comb begin
        for (int r = 0; r < k - 1; r++) begin
            newcol[r] = lb_tap[k-2-r];
        end
        newcol[k-1] = in_pix;
    end

    always_comb begin
        for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k - 1; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
            win_nxt[r][k-1] = newcol[r];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win <= win_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col       <= '0;
            row       <= '0;
            ch        <= '0;
            state     <= st_fill;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            for (int r = 0; r < k; r++) begin
                for (int c = 0; c < k; c++) begin
                    out_win[r][c] <= '0;
                end
            end
        end else begin
            if (accept) begin
                if (at_col_end) begin
                    col <= '0;
                    if (at_row_end) begin
                        row   <= '0;
                        ch    <= (ch == ch_last) ? '0 : ch + chw'(1);
                        state <= st_fill;
                    end else begin
                        row <= row + roww'(1);
                        if (row == row_prime) begin
                            state <= st_stream;
                        end
                    end
                end else begin
                    col <= col + colw'(1);
                end
            end

            // A new window replaces the old one in the same cycle it drains.
            if (emit) begin
                out_valid <= 1'b1;
                out_win   <= win_nxt;
                out_ch    <= ch;
                out_last  <= at_row_end && at_col_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_window_linebuf.sv
// Randomised bench for conv_window_linebuf; windows are predicted directly
// from plane contents and compared against everything the DUT hands over.
module tb_conv_window_linebuf;
    import cnn_pkg::*;

    localparam int W = 14;
    localparam int H = 14;
    localparam int D = 6;
    localparam int K = 5;
    localparam int WB = K * K * 16;

    typedef struct packed {
        logic [WB-1:0] w;
        logic [2:0]    ch;
        logic          last;
        logic          fd;
        int            cyc;
    } cap_t;

    logic clk = 1'b0;
    logic rst;
    pix_t in_pix;
    logic in_valid;
    logic in_ready;
    pix_t out_win [0:K-1][0:K-1];
    logic out_valid;
    logic out_ready;
    logic [2:0] out_ch;
    logic out_last;
    logic frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_count = 0;

    cap_t cap_q[$];
    cap_t exp_q[$];
    pix_t send_q[$];
    int   acc_q[$];
    pix_t plane_pix [0:H-1][0:W-1];
    cap_t mon_c;

    conv_window_linebuf #(.width(W), .height(H), .depth(D), .k(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_pix     (in_pix),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_win    (out_win),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WB-1:0] flat_win();
        logic [WB-1:0] f;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                f[(r*K+c)*16 +: 16] = out_win[r][c];
        return f;
    endfunction

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            mon_c.w    = flat_win();
            mon_c.ch   = out_ch;
            mon_c.last = out_last;
            mon_c.fd   = frame_done;
            mon_c.cyc  = cyc;
            cap_q.push_back(mon_c);
        end
        if (rst && frame_done) fd_count++;
    end

    // Reference: every position with row,col >= K-1 yields the K x K block ending there.
    task automatic make_plane(input int offset, input bit rnd, input int ch, input int npix);
        cap_t e;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                plane_pix[r][c] = rnd ? pix_t'($urandom) : pix_t'(r * W + c + offset);
        for (int i = 0; i < npix; i++) begin
            int r;
            int c;
            r = i / W;
            c = i % W;
            send_q.push_back(plane_pix[r][c]);
            if (r >= K - 1 && c >= K - 1) begin
                e = '0;
                for (int wr = 0; wr < K; wr++)
                    for (int wc = 0; wc < K; wc++)
                        e.w[(wr*K+wc)*16 +: 16] = plane_pix[r-K+1+wr][c-K+1+wc];
                e.ch   = 3'(ch);
                e.last = (r == H - 1) && (c == W - 1);
                e.fd   = e.last && (ch == D - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cap_q.delete();
        exp_q.delete();
        send_q.delete();
        acc_q.delete();
        fd_count = 0;
    endtask

    task automatic drive(input int vpct, input int rpct);
        int idx = 0;
        int budget = 0;
        while (idx < send_q.size() && budget < 20000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(99) < vpct);
            in_pix    = send_q[idx];
            out_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            if (in_valid && in_ready) begin
                acc_q.push_back(cyc);
                idx++;
            end
            budget++;
        end
        if (idx < send_q.size()) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: sent %0d of %0d pixels", idx, send_q.size());
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        checks++; if (out_ch !== 3'd0) begin errors++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (flat_win() !== '0) begin errors++; $display("FAIL reset_out_win: got nonzero want all 0"); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_ramp();
        do_reset();
        make_plane(0, 1'b0, 0, W * H);
        drive(100, 100);
        checks++;
        if (cap_q.size() !== 100) begin errors++; $display("FAIL ramp_count: got %0d want 100", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].w !== exp_q[i].w || cap_q[i].ch !== exp_q[i].ch || cap_q[i].last !== exp_q[i].last) begin
                errors++;
                $display("FAIL ramp_win[%0d]: got ch %0d last %0d w00 %0d w44 %0d want ch %0d last %0d w00 %0d w44 %0d", i,
                         cap_q[i].ch, cap_q[i].last, cap_q[i].w[15:0], cap_q[i].w[24*16 +: 16],
                         exp_q[i].ch, exp_q[i].last, exp_q[i].w[15:0], exp_q[i].w[24*16 +: 16]);
            end
        end
        if (cap_q.size() >= 100 && acc_q.size() > 60) begin
            checks++;
            if (cap_q[0].w[15:0] !== 16'd0 || cap_q[0].w[24*16 +: 16] !== 16'd60) begin
                errors++; $display("FAIL ramp_first: got w00 %0d w44 %0d want 0 60", cap_q[0].w[15:0], cap_q[0].w[24*16 +: 16]);
            end
            checks++;
            if (cap_q[0].cyc !== acc_q[60] + 1) begin
                errors++; $display("FAIL ramp_latency: got cycle %0d want %0d", cap_q[0].cyc, acc_q[60] + 1);
            end
            checks++;
            if (cap_q[99].w[24*16 +: 16] !== 16'd195 || cap_q[99].last !== 1'b1) begin
                errors++; $display("FAIL ramp_last: got w44 %0d last %b want 195 1", cap_q[99].w[24*16 +: 16], cap_q[99].last);
            end
        end else begin
            checks++; errors++; $display("FAIL ramp_short: got %0d windows want 100", cap_q.size());
        end
    endtask

    task automatic test_row_boundary();
        do_reset();
        make_plane(0, 1'b0, 0, W * H);
        drive(100, 100);
        if (cap_q.size() > 10) begin
            checks++;
            if (cap_q[10].w[15:0] !== 16'd14 || cap_q[10].w[24*16 +: 16] !== 16'd74) begin
                errors++; $display("FAIL row_boundary_win: got w00 %0d w44 %0d want 14 74", cap_q[10].w[15:0], cap_q[10].w[24*16 +: 16]);
            end
        end else begin
            checks++; errors++; $display("FAIL row_boundary_short: got %0d windows want 100", cap_q.size());
        end
        for (int i = 0; i < cap_q.size(); i++) begin
            int j;
            j = -1;
            for (int a = 0; a < acc_q.size(); a++)
                if (acc_q[a] == cap_q[i].cyc - 1) j = a;
            checks++;
            if (j < 0 || (j % W) < K - 1 || (j / W) < K - 1) begin
                errors++; $display("FAIL row_boundary_src[%0d]: got source pixel %0d want row,col >= %0d", i, j, K - 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int budget = 0;
        bit stalled = 0;
        logic [WB-1:0] held_w = '0;
        logic [2:0] held_ch = '0;
        logic held_last = 1'b0;
        do_reset();
        make_plane(0, 1'b0, 0, W * H);
        while (idx < send_q.size() && budget < 20000) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_pix    = send_q[idx];
            out_ready = ($urandom_range(99) < 30);
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || flat_win() !== held_w || out_ch !== held_ch || out_last !== held_last) begin
                    errors++;
                    $display("FAIL bp_hold: got valid %b ch %0d last %b w44 %0d want valid 1 ch %0d last %b w44 %0d",
                             out_valid, out_ch, out_last, out_win[4][4], held_ch, held_last, held_w[24*16 +: 16]);
                end
            end
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++; $display("FAIL bp_in_ready: got %b want %b", in_ready, !out_valid || out_ready);
            end
            stalled   = out_valid && !out_ready;
            held_w    = flat_win();
            held_ch   = out_ch;
            held_last = out_last;
            if (in_valid && in_ready) idx++;
            budget++;
        end
        if (idx < send_q.size()) begin
            checks++; errors++; $display("FAIL bp_timeout: sent %0d of %0d pixels", idx, send_q.size());
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].w !== exp_q[i].w || cap_q[i].ch !== exp_q[i].ch || cap_q[i].last !== exp_q[i].last) begin
                errors++; $display("FAIL bp_win[%0d]: got w44 %0d ch %0d want w44 %0d ch %0d", i,
                                   cap_q[i].w[24*16 +: 16], cap_q[i].ch, exp_q[i].w[24*16 +: 16], exp_q[i].ch);
            end
        end
    endtask

    task automatic test_back_to_back_planes();
        do_reset();
        for (int c = 0; c < D; c++) make_plane(1000 * c, 1'b0, c, W * H);
        make_plane(0, 1'b0, 0, (K - 1) * W + K);
        drive(100, 100);
        checks++;
        if (cap_q.size() !== 601) begin errors++; $display("FAIL planes_count: got %0d want 601", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].w !== exp_q[i].w || cap_q[i].ch !== exp_q[i].ch || cap_q[i].last !== exp_q[i].last || cap_q[i].fd !== exp_q[i].fd) begin
                errors++; $display("FAIL planes_win[%0d]: got ch %0d last %b fd %b w44 %0d want ch %0d last %b fd %b w44 %0d", i,
                                   cap_q[i].ch, cap_q[i].last, cap_q[i].fd, cap_q[i].w[24*16 +: 16],
                                   exp_q[i].ch, exp_q[i].last, exp_q[i].fd, exp_q[i].w[24*16 +: 16]);
            end
        end
        checks++;
        if (fd_count !== 1) begin errors++; $display("FAIL planes_frame_done_count: got %0d want 1", fd_count); end
        if (cap_q.size() > 600) begin
            checks++;
            if (cap_q[599].fd !== 1'b1 || cap_q[600].ch !== 3'd0) begin
                errors++; $display("FAIL planes_wrap: got fd599 %b ch600 %0d want 1 0", cap_q[599].fd, cap_q[600].ch);
            end
        end
    endtask

    task automatic test_reset_mid_plane();
        do_reset();
        make_plane(0, 1'b0, 0, W * H);
        make_plane(1000, 1'b0, 1, 79);
        drive(100, 100);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_pix    = plane_pix[5][9];
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_accept: got in_ready %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 3'd1) begin
            errors++; $display("FAIL rstmid_pending: got valid %b ch %0d want 1 1", out_valid, out_ch);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        checks++; if (out_ch !== 3'd0 || out_last !== 1'b0) begin errors++; $display("FAIL rstmid_ch_last: got %0d %b want 0 0", out_ch, out_last); end
        checks++; if (flat_win() !== '0) begin errors++; $display("FAIL rstmid_out_win: got nonzero want all 0"); end
        checks++; if (in_ready !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_ready_fd: got %b %b want 1 0", in_ready, frame_done); end
        @(negedge clk);
        rst = 1'b1;
        cap_q.delete();
        exp_q.delete();
        send_q.delete();
        acc_q.delete();
        make_plane(0, 1'b0, 0, W * H);
        drive(100, 100);
        checks++;
        if (cap_q.size() !== 100) begin errors++; $display("FAIL rstmid_count: got %0d want 100", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].w !== exp_q[i].w || cap_q[i].ch !== exp_q[i].ch || cap_q[i].last !== exp_q[i].last) begin
                errors++; $display("FAIL rstmid_win[%0d]: got w44 %0d ch %0d want w44 %0d ch %0d", i,
                                   cap_q[i].w[24*16 +: 16], cap_q[i].ch, exp_q[i].w[24*16 +: 16], exp_q[i].ch);
            end
        end
    endtask

    task automatic test_gaps(input bit rnd_data);
        do_reset();
        make_plane(0, rnd_data, 0, W * H);
        drive(55, rnd_data ? 60 : 100);
        checks++;
        if (cap_q.size() !== 100) begin errors++; $display("FAIL gaps_count: got %0d want 100", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].w !== exp_q[i].w || cap_q[i].ch !== exp_q[i].ch || cap_q[i].last !== exp_q[i].last) begin
                errors++; $display("FAIL gaps_win[%0d]: got w00 %0d w44 %0d want w00 %0d w44 %0d", i,
                                   cap_q[i].w[15:0], cap_q[i].w[24*16 +: 16], exp_q[i].w[15:0], exp_q[i].w[24*16 +: 16]);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_pix = '0;
        out_ready = 1'b0;
        test_reset();
        test_ramp();
        test_row_boundary();
        test_backpressure();
        test_back_to_back_planes();
        test_reset_mid_plane();
        test_gaps(1'b0);
        test_gaps(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
